// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the EXE-stage multiply/divide unit.
// Imported by exe_muldiv and its divider core.
package muldiv_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_PRE,
    DIV_ITER,
    DIV_FIX,
    DONE
  } state_e;

  // Widest operand abs_w can handle; callers truncate to their own width.
  localparam int ABS_W = 128;

  // Magnitude of a width-bit value, negating only in signed mode.
  // Negating in ABS_W bits leaves the low width bits correct.
  function automatic logic [ABS_W-1:0] abs_w(
    input logic [ABS_W-1:0] value,
    input logic             signed_en,
    input int               width
  );
    logic neg;
    neg = signed_en && value[width[6:0] - 7'd1];
    return neg ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Restoring radix-2 divider datapath: one quotient bit per step pulse.
// The parent sequences load/step and applies any sign correction.
import muldiv_pkg::*;

module div_radix2_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] rem_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] dvs_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // Partial remainder is W+1 bits only transiently, after the shift.
  assign shifted = {rem_q, quo_q[W-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Load operands, then shift in one dividend bit per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      if (!diff[W]) begin
        rem_q <= diff[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= shifted[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// Sequenced MULT/DIV unit for the EXE stage with valid/ready on both
// sides, pipelined multiplier, iterative divider and flush support.
import muldiv_pkg::*;

module exe_muldiv #(
  parameter int W       = 32,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_op,
  input  logic         req_signed,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_hi,
  output logic [W-1:0] resp_lo,
  output logic         resp_dbz,
  output logic         busy
);

  localparam int MAXV = (MUL_LAT > W) ? MUL_LAT : W;
  localparam int CW   = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

  state_e         state;
  state_e         state_next;
  state_e         first_state;
  logic [CW-1:0]  cnt;
  logic           accept;

  logic           sgn_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           q_neg;
  logic           r_neg;
  logic           dbz_q;

  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  logic [2*W-1:0] ma;
  logic [2*W-1:0] mb;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] mul_out;

  assign req_ready = !flush &&
                     (state == IDLE ||
                      (state == DONE && resp_ready));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  assign first_state = (op_e'(req_op) == OP_DIV) ? DIV_PRE : MUL;

  // Next-state: sequence the op, flush overrides everything.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (accept) state_next = first_state;
      MUL:      if (cnt == MUL_LAST) state_next = DONE;
      DIV_PRE:  state_next = DIV_ITER;
      DIV_ITER: if (cnt == DIV_LAST) state_next = DIV_FIX;
      DIV_FIX:  state_next = DONE;
      DONE: begin
        if (accept)          state_next = first_state;
        else if (resp_ready) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Cycle counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (reset || state_next != state)
      cnt <= '0;
    else if (state == MUL || state == DIV_ITER)
      cnt <= cnt + 1'b1;
  end

  // Capture operands and mode on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      sgn_q <= req_signed;
      a_q   <= req_a;
      b_q   <= req_b;
    end
  end

  // Record result signs and divide-by-zero before iterating.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dbz_q <= 1'b0;
    end else if (state == DIV_PRE) begin
      q_neg <= sgn_q & (a_q[W-1] ^ b_q[W-1]);
      r_neg <= sgn_q & a_q[W-1];
      dbz_q <= (b_q == '0);
    end
  end

  assign abs_a = W'(abs_w(ABS_W'(a_q), sgn_q, W));
  assign abs_b = W'(abs_w(ABS_W'(b_q), sgn_q, W));

  div_radix2_core #(.W(W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (state == DIV_PRE),
    .step      (state == DIV_ITER),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  assign q_fix = q_neg ? -quo : quo;
  assign r_fix = r_neg ? -rem : rem;

  assign ma   = {{W{sgn_q & a_q[W-1]}}, a_q};
  assign mb   = {{W{sgn_q & b_q[W-1]}}, b_q};
  assign prod = ma * mb;

  if (MUL_LAT == 1) begin : g_mul_comb
    assign mul_out = prod;
  end else begin : g_mul_pipe
    logic [2*W-1:0] stage [MUL_LAT-1];

    // Product pipeline; flush discards what is in flight.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        for (int i = 0; i < MUL_LAT - 1; i++)
          stage[i] <= '0;
      end else begin
        stage[0] <= prod;
        for (int i = 1; i < MUL_LAT - 1; i++)
          stage[i] <= stage[i-1];
      end
    end

    assign mul_out = stage[MUL_LAT-2];
  end

  // Result registers: loaded on entry to DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_hi  <= '0;
      resp_lo  <= '0;
      resp_dbz <= 1'b0;
    end else if (state == MUL && state_next == DONE) begin
      {resp_hi, resp_lo} <= mul_out;
      resp_dbz           <= 1'b0;
    end else if (state == DIV_FIX && state_next == DONE) begin
      resp_lo  <= dbz_q ? '1  : q_fix;
      resp_hi  <= dbz_q ? a_q : r_fix;
      resp_dbz <= dbz_q;
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: W=32/MUL_LAT=2 and W=16/MUL_LAT=1.
// Stimulus pushes expected results; monitors pop on each response.
module tb_exe_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush;
  logic        req_valid, req_ready, req_op, req_signed;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready, resp_dbz, busy;
  logic [31:0] resp_hi, resp_lo;

  logic        req_valid2, req_ready2, req_op2, req_signed2;
  logic [15:0] req_a2, req_b2;
  logic        resp_valid2, resp_ready2, resp_dbz2, busy2;
  logic [15:0] resp_hi2, resp_lo2;

  exe_muldiv #(.W(32), .MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo),
    .resp_dbz(resp_dbz), .busy(busy)
  );

  exe_muldiv #(.W(16), .MUL_LAT(1)) dut2 (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op2), .req_signed(req_signed2),
    .req_a(req_a2), .req_b(req_b2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_hi(resp_hi2), .resp_lo(resp_lo2),
    .resp_dbz(resp_dbz2), .busy(busy2)
  );

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  bit   seen1 = 0;
  bit   seen2 = 0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp_v);
    end
  endtask

  // Monitor for the 32-bit unit.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb1.size() == 0) begin
        chk("w32_unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        if (!seen1) begin
          seen1 = 1;
          chk("w32_latency", 64'(cyc), 64'(sb1[0].due));
        end
        if (resp_ready) begin
          chk("w32_hi", 64'(resp_hi), 64'(sb1[0].res[63:32]));
          chk("w32_lo", 64'(resp_lo), 64'(sb1[0].res[31:0]));
          chk("w32_dbz", 64'(resp_dbz), 64'(sb1[0].dbz));
          void'(sb1.pop_front());
          seen1 = 0;
        end
      end
    end
  end

  // Monitor for the 16-bit unit.
  always @(negedge clk) begin
    if (!reset && resp_valid2) begin
      if (sb2.size() == 0) begin
        chk("w16_unexpected_resp", 64'(resp_valid2), 64'd0);
      end else begin
        if (!seen2) begin
          seen2 = 1;
          chk("w16_latency", 64'(cyc), 64'(sb2[0].due));
        end
        if (resp_ready2) begin
          chk("w16_hi", 64'(resp_hi2), 64'(sb2[0].res[31:16]));
          chk("w16_lo", 64'(resp_lo2), 64'(sb2[0].res[15:0]));
          chk("w16_dbz", 64'(resp_dbz2), 64'(sb2[0].dbz));
          void'(sb2.pop_front());
          seen2 = 0;
        end
      end
    end
  end

  task automatic issue(input logic op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic dbz,
                       input int lat, input bit push);
    int   n;
    exp_t e;
    n = 0;
    req_op = op; req_signed = sgn;
    req_a = a; req_b = b; req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      chk("w32_issue_timeout", 64'(req_ready), 64'd1);
    end else if (push) begin
      e.res = res; e.dbz = dbz; e.due = cyc + 1 + lat;
      sb1.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    req_op = 1'($urandom); req_signed = 1'($urandom);
  endtask

  task automatic issue2(input logic op, input logic sgn,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] res, input logic dbz,
                        input int lat);
    int   n;
    exp_t e;
    n = 0;
    req_op2 = op; req_signed2 = sgn;
    req_a2 = a; req_b2 = b; req_valid2 = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready2 && n < 200);
    if (!req_ready2) begin
      chk("w16_issue_timeout", 64'(req_ready2), 64'd1);
    end else begin
      e.res = 64'(res); e.dbz = dbz; e.due = cyc + 1 + lat;
      sb2.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    req_a2 = 16'($urandom); req_b2 = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb1", 64'(sb1.size()), 64'd0);
    chk("drain_sb2", 64'(sb2.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int vcount;
    reset = 1; flush = 0;
    req_valid = 0; req_op = 0; req_signed = 0;
    req_a = 0; req_b = 0; resp_ready = 1;
    req_valid2 = 0; req_op2 = 0; req_signed2 = 0;
    req_a2 = 0; req_b2 = 0; resp_ready2 = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_hi", 64'(resp_hi), 64'd0);
    chk("rst_lo", 64'(resp_lo), 64'd0);
    chk("rst_dbz", 64'(resp_dbz), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy2", 64'(busy2), 64'd0);
    @(posedge clk);
    #1;

    // MULT vectors
    issue(0, 1, 32'hFFFFFFFD, 32'd7,
          64'hFFFFFFFF_FFFFFFEB, 0, 2, 1);
    issue(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF,
          64'hFFFFFFFE_00000001, 0, 2, 1);
    issue(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF,
          64'h00000000_00000001, 0, 2, 1);
    // DIV vectors: {rem, quo}
    issue(1, 0, 32'd100, 32'd7,
          64'h00000002_0000000E, 0, 34, 1);
    issue(1, 1, 32'hFFFFFFF9, 32'd2,
          64'hFFFFFFFF_FFFFFFFD, 0, 34, 1);
    issue(1, 1, 32'h80000000, 32'hFFFFFFFF,
          64'h00000000_80000000, 0, 34, 1);
    issue(1, 0, 32'hFFFFFFFF, 32'd2,
          64'h00000001_7FFFFFFF, 0, 34, 1);
    issue(1, 1, 32'd7, 32'hFFFFFFFE,
          64'h00000001_FFFFFFFD, 0, 34, 1);
    // divide by zero
    issue(1, 1, 32'd5, 32'd0,
          64'h00000005_FFFFFFFF, 1, 34, 1);
    issue(1, 0, 32'd5, 32'd0,
          64'h00000005_FFFFFFFF, 1, 34, 1);
    issue(1, 1, 32'hFFFFFFFB, 32'd0,
          64'hFFFFFFFB_FFFFFFFF, 1, 34, 1);
    drain();

    // flush at DIV_ITER step 10
    issue(1, 0, 32'd1000, 32'd3, 64'd0, 0, 34, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1;
    req_valid = 1; req_op = 0; req_a = 9; req_b = 9;
    @(negedge clk);
    chk("flush_req_ready", 64'(req_ready), 64'd0);
    chk("flush_busy_pre", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush = 0; req_valid = 0;
    @(negedge clk);
    chk("flush_resp_valid", 64'(resp_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_req_ready_after", 64'(req_ready), 64'd1);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) vcount++;
    end
    chk("flush_no_resp", 64'(vcount), 64'd0);
    @(posedge clk);
    #1;
    issue(0, 0, 32'd2, 32'd3, 64'd6, 0, 2, 1);
    drain();

    // backpressure, then back-to-back accept
    resp_ready = 0;
    issue(0, 0, 32'h12345678, 32'h10,
          64'h00000001_23456780, 0, 2, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 50);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_hi", 64'(resp_hi), 64'h1);
      chk("bp_lo", 64'(resp_lo), 64'h23456780);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1;
    issue(0, 1, 32'hFFFFFFFF, 32'd2,
          64'hFFFFFFFF_FFFFFFFE, 0, 2, 1);
    issue(1, 0, 32'd9, 32'd4,
          64'h00000001_00000002, 0, 34, 1);
    drain();

    // reset in the middle of a DIV clears outputs
    issue(1, 0, 32'd50, 32'd5, 64'd0, 0, 34, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_lo", 64'(resp_lo), 64'd0);
    chk("mid_rst_hi", 64'(resp_hi), 64'd0);
    @(posedge clk);
    #1;

    // W=16, MUL_LAT=1
    resp_ready2 = 0;
    issue2(0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid2 && n < 50);
    for (int i = 0; i < 3; i++) begin
      chk("bp16_hi", 64'(resp_hi2), 64'hFFFE);
      chk("bp16_lo", 64'(resp_lo2), 64'h0001);
      chk("bp16_req_ready", 64'(req_ready2), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready2 = 1;
    issue2(0, 1, 16'hFFFF, 16'hFFFF, 32'h00000001, 0, 1);
    issue2(1, 1, 16'hFFF9, 16'd2, 32'hFFFFFFFD, 0, 18);
    issue2(1, 0, 16'd5, 16'd0, 32'h0005FFFF, 1, 18);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Parametrised multiply/divide unit for the EXE stage. It replaces the fixed 32-bit multiplier/divider pair with a single sequenced block. The block accepts one MULT or DIV request at a time over a valid/ready handshake and returns a 2·W-bit {HI,LO} result, holding it until the consumer accepts it. It supports a pipelined multiplier of configurable latency, an iterative radix-2 divider, signed and unsigned modes, a divide-by-zero flag, and a flush that cancels any operation in flight.

## Interface
- W, 32: operand width in bits (≥ 4).
- MUL_LAT, 2: multiplier latency in cycles (≥ 1).

- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  cancels the current operation (exception or branch clear).
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_op  input  1  0 = MULT, 1 = DIV.
- req_signed  input  1  1 = signed (two's complement), 0 = unsigned.
- req_a  input  W  multiplicand or dividend.
- req_b  input  W  multiplier or divisor.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_hi  output  W  MULT: product[2W-1:W]. DIV: remainder.
- resp_lo  output  W  MULT: product[W-1:0]. DIV: quotient.
- resp_dbz  output  1  DIV with req_b == 0.
- busy  output  1  state is not IDLE.

## Operation
- States and transitions:
  - IDLE: on accept with op = 0, go to MUL; with op = 1, go to DIV_PRE.
  - MUL: count MUL_LAT−1 cycles, then go to DONE.
  - DIV_PRE: latch |a| and |b| (absolute values taken only when signed), and record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)). Go to DIV_ITER.
  - DIV_ITER: W restoring steps, one quotient bit per cycle, with a partial remainder of W+1 bits. Go to DIV_FIX.
  - DIV_FIX: negate the quotient and/or remainder as required by the recorded signs. Go to DONE.
  - DONE: resp_valid = 1. On resp_ready, go to IDLE, or directly to the next op's first state if a new request is accepted in the same cycle.
- Handshake:
  - Accept occurs when req_valid && req_ready.
  - req_ready = !flush && (IDLE || (DONE && resp_ready)).
  - Operands and mode are captured on accept. The requester may change its inputs on the following cycle.
- MULT: full 2W-bit product. Signed mode sign-extends both operands. Pipeline registers carry the product through MUL_LAT stages and may be retimed.
- DIV sign rule: the quotient truncates toward zero, and the remainder takes the dividend's sign.
- Signed overflow: min / −1 gives Q = min, R = 0. This falls out of the absolute-value path and needs no special case.
- Divide by zero:
  - Q = all ones, R = req_a unchanged, resp_dbz = 1.
  - Latency is the same as a normal DIV; the iteration still runs, and the results are forced in DIV_FIX.
- resp_hi, resp_lo and resp_dbz stay stable while resp_valid && !resp_ready.

## Timing
- Reset, and the cycle after reset deasserts:
  - State = IDLE, resp_valid = 0, resp_hi = resp_lo = 0, resp_dbz = 0, busy = 0.
  - req_ready = 1 unless flush is high.
- Accept at edge k:
  - MULT: resp_valid = 1 from cycle k+MUL_LAT.
  - DIV: resp_valid = 1 from cycle k+W+2.
- Back-to-back: a result accepted in the same cycle as a new request leaves no idle bubble.
- Flush:
  - Any state returns to IDLE at the next edge, and resp_valid drops at that edge.
  - No request is accepted in a flush cycle.
  - The multiplier pipeline contents are discarded.
  - Flush has priority over resp_ready.
- Reset mid-operation behaves like flush and also clears the outputs to zero.
- Both the MUL and DIV_ITER counters are log2(max(MUL_LAT, W))+1 bits wide, with no wrap in normal use.

## Structure
- Package muldiv_pkg:
  - op encoding (OP_MUL = 0, OP_DIV = 1).
  - state encoding (IDLE, MUL, DIV_PRE, DIV_ITER, DIV_FIX, DONE).
  - function abs_w(value, signed_en).
- Sub-module div_radix2_core(W): holds the partial remainder and quotient shift registers. It performs one restoring step per enable pulse and has a load input for the divisor and dividend. The parent owns the FSM, the sign fix-up and the result registers.

## Test plan
1. Signed MULT, −3 × 7, W=32, MUL_LAT=2 → {hi,lo} = 0xFFFFFFFF_FFFFFFEB, with resp_valid at k+2.
2. Unsigned DIV, 100 / 7 → lo = 14, hi = 2, with resp_valid at k+34.
3. Signed DIV:
   - −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
   - 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
   - Unsigned 0xFFFFFFFF / 2 → lo = 0x7FFFFFFF, hi = 1.
4. Divide by zero, 5 / 0 (signed and unsigned) → lo = 0xFFFFFFFF, hi = 5, resp_dbz = 1, latency 34.
5. Flush during DIV_ITER step 10 → resp_valid never rises and req_ready = 1 at the next cycle. A following MULT 2 × 3 → lo = 6, hi = 0.
6. Backpressure:
   - resp_ready held low for 5 cycles → outputs stable and req_ready = 0.
   - resp_ready and req_valid high together → new request accepted with no bubble.
   - Repeat with W=16, MUL_LAT=1: 0xFFFF × 0xFFFF unsigned → 0xFFFE_0001 at k+1.
